outer1bits_span: RTL and testbench
==================================

// Module: outer1bits_span
// PURPOSE
//   Downstream stage of outer1bits. Consumes its per-word leftmost/rightmost
//   set-bit one-hot masks and encodes them to bit indices and a span width.
//   Buffers results in a small FIFO with valid/ready output, because the
//   upstream stage cannot be stalled.
//   Flags malformed masks and FIFO overflow.
// PARAMETERS
//   WIDTH       4   data word width; same as upstream data_i width
//   FIFO_DEPTH  4   result FIFO entries, >=2
//   IDX_W       localparam = $clog2(WIDTH); index width
//   CNT_W       localparam = $clog2(FIFO_DEPTH+1); fill-count width
// PORTS
//   clk_i         in   1         clock, all logic on rising edge
//   srst_n_i      in   1         reset: synchronous, active-low
//   data_val_i    in   1         upstream word valid, no backpressure
//   data_left_i   in   WIDTH     leftmost set bit, one-hot or zero
//   data_right_i  in   WIDTH     rightmost set bit, one-hot or zero
//   data_val_o    out  1         FIFO head valid
//   data_ready_i  in   1         consumer ready; pop on val_o&&ready_i
//   left_idx_o    out  IDX_W     index of left bit
//   right_idx_o   out  IDX_W     index of right bit
//   span_o        out  IDX_W+1   left_idx-right_idx+1, 0 if zero word
//   zero_o        out  1         head word had no set bits
//   fill_o        out  CNT_W     FIFO occupancy
//   err_o         out  1         sticky: malformed input seen
//   ovf_o         out  1         sticky: word dropped on full FIFO
// BEHAVIOUR
//   Reset (srst_n_i=0 at an edge)
//     - FIFO emptied; capture stage invalidated.
//     - All outputs go to 0.
//     - Mid-operation reset discards all in-flight and buffered words.
//   Stage 1 (capture register)
//     - data_val_i=1 at edge k: masks registered and encoded.
//     - Edge k+1: the word is pushed into the FIFO.
//     - If the FIFO was empty, data_val_o=1 after edge k+1 (FWFT).
//     - Latency: 2 edges, sustained throughput 1 word/cycle.
//   Encode
//     - idx = position of the single set bit.
//     - span = left_idx - right_idx + 1, computed in IDX_W+1 bits with no
//       overflow.
//     - Both masks zero: zero_o=1, idx=0, span=0.
//   Malformed input, any of:
//     - either mask has >1 bit set;
//     - exactly one mask is zero;
//     - left_idx < right_idx.
//     The word is not pushed; err_o is set at edge k+1.
//   FIFO
//     - Push when stage 1 holds a well-formed word.
//     - Pop when data_val_o && data_ready_i.
//     - Full + push + pop in the same cycle: both happen, fill unchanged.
//     - Full + push without pop: word dropped; ovf_o is set; fill stays
//       FIFO_DEPTH.
//     - Empty: data_val_o=0; data outputs hold the last value (don't care).
//     - Order is strictly preserved; pointers wrap modulo FIFO_DEPTH.
//   Sticky flags err_o and ovf_o clear only on reset.
// TESTING
//   1. left=0100,right=0010,ready=1 -> 2 edges later val_o=1, idx 2/1,
//      span=2, zero=0.
//   2. left=0000,right=0000 -> val_o=1, zero_o=1, idx 0/0, span=0.
//   3. left=1000,right=0001 -> span=4 (3'b100); then left=0001,right=0001
//      -> span=1.
//   4. left=0011, or left=0010 with right=0100 -> no output word; err_o=1
//      at edge k+1 and held until reset.
//   5. ready=0, 5 consecutive valid words -> fill_o=4, ovf_o=1; ready=1
//      drains the first 4 in order.
//   6. FIFO full with push+pop in one cycle -> fill stays 4, ovf_o=0.
//      Reset with fill=3 -> next edge fill=0, val_o=0, flags 0.

Source files
------------

// File: rtl/outer1bits_span.sv
// Encodes the upstream leftmost/rightmost one-hot masks into bit indices and a span,
// then buffers the results in a first-word-fall-through FIFO with sticky error/overflow flags.
module outer1bits_span #(
   parameter  int WIDTH      = 4,
   parameter  int FIFO_DEPTH = 4,
   localparam int IDX_W      = $clog2(WIDTH),
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             srst_n_i,
   input  logic             data_val_i,
   input  logic [WIDTH-1:0] data_left_i,
   input  logic [WIDTH-1:0] data_right_i,
   output logic             data_val_o,
   input  logic             data_ready_i,
   output logic [IDX_W-1:0] left_idx_o,
   output logic [IDX_W-1:0] right_idx_o,
   output logic [IDX_W:0]   span_o,
   output logic             zero_o,
   output logic [CNT_W-1:0] fill_o,
   output logic             err_o,
   output logic             ovf_o
);

   localparam int                PTR_W    = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

   typedef struct packed {
      logic [IDX_W-1:0] left_idx;
      logic [IDX_W-1:0] right_idx;
      logic [IDX_W:0]   span;
      logic             zero;
   } entry_t;

   function automatic logic multi_hot(input logic [WIDTH-1:0] m);
      return (m & (m - WIDTH'(1))) != '0;
   endfunction

   // Only meaningful for one-hot masks; multi-hot words are rejected anyway.
   function automatic logic [IDX_W-1:0] encode(input logic [WIDTH-1:0] m);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (m[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   // ---------------------------------------------------------------
   // Stage 1: capture register
   // ---------------------------------------------------------------
   logic             s1_val;
   logic [WIDTH-1:0] s1_left;
   logic [WIDTH-1:0] s1_right;

   // NOTE: sequential state is always assigned with <= so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         s1_val   <= 1'b0;
         s1_left  <= '0;
         s1_right <= '0;
      end else begin
         s1_val <= data_val_i;
         if (data_val_i) begin
            s1_left  <= data_left_i;
            s1_right <= data_right_i;
         end
      end
   end

   // ---------------------------------------------------------------
   // Encode and validity check of the captured word
   // ---------------------------------------------------------------
   logic [IDX_W-1:0] l_idx;
   logic [IDX_W-1:0] r_idx;
   logic             l_zero;
   logic             r_zero;
   logic             s1_bad;
   entry_t           s1_entry;

   // NOTE: every always_comb output gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      l_idx    = encode(s1_left);
      r_idx    = encode(s1_right);
      l_zero   = (s1_left == '0);
      r_zero   = (s1_right == '0);
      s1_bad   = 1'b0;
      s1_entry = '0;

      if (multi_hot(s1_left) || multi_hot(s1_right) || (l_zero != r_zero))
         s1_bad = 1'b1;
      else if (!l_zero && (l_idx < r_idx))
         s1_bad = 1'b1;

      s1_entry.left_idx  = l_idx;
      s1_entry.right_idx = r_idx;
      s1_entry.zero      = l_zero && r_zero;
      if (!(l_zero && r_zero))
         s1_entry.span = {1'b0, l_idx} - {1'b0, r_idx} + (IDX_W + 1)'(1);
   end

   // ---------------------------------------------------------------
   // Result FIFO (first word falls through to the outputs)
   // ---------------------------------------------------------------
   entry_t           mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] fill;
   logic             err;
   logic             ovf;

   logic full;
   logic pop;
   logic push_req;
   logic push;
   logic drop;

   assign full     = (fill == FULL_CNT);
   assign pop      = data_val_o && data_ready_i;
   assign push_req = s1_val && !s1_bad;
   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign push     = push_req && (!full || pop);
   assign drop     = push_req && full && !pop;

   always_ff @(posedge clk_i) begin
      if (!srst_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
         err    <= 1'b0;
         ovf    <= 1'b0;
         // NOTE: the storage is cleared on reset because the head entry drives
         // the outputs directly and they must read zero after reset.
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= s1_entry;
            wr_ptr      <= ptr_next(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_next(rd_ptr);

         if (push && !pop)      fill <= fill + CNT_W'(1);
         else if (!push && pop) fill <= fill - CNT_W'(1);

         if (s1_val && s1_bad) err <= 1'b1;
         if (drop)             ovf <= 1'b1;
      end
   end

   entry_t head;
   assign head        = mem[rd_ptr];
   assign data_val_o  = (fill != '0);
   assign left_idx_o  = head.left_idx;
   assign right_idx_o = head.right_idx;
   assign span_o      = head.span;
   assign zero_o      = head.zero;
   assign fill_o      = fill;
   assign err_o       = err;
   assign ovf_o       = ovf;

endmodule

// File: tb/tb_outer1bits_span.sv
// Directed self-checking bench for outer1bits_span: encode, latency, malformed words,
// FIFO overflow, full push+pop, ordering across pointer wrap and mid-operation reset.
module tb_outer1bits_span;

   logic       clk = 1'b0;
   logic       srst_n = 1'b0;
   logic       data_val = 1'b0;
   logic [3:0] data_left = '0;
   logic [3:0] data_right = '0;
   logic       data_ready = 1'b0;
   logic       val_o;
   logic [1:0] left_idx;
   logic [1:0] right_idx;
   logic [2:0] span;
   logic       zero;
   logic [2:0] fill;
   logic       err;
   logic       ovf;

   int checks = 0;
   int failures = 0;

   // Directed word set: masks plus hand-computed left/right index and span.
   logic [3:0] wl [5] = '{4'b1000, 4'b1000, 4'b0100, 4'b0010, 4'b1000};
   logic [3:0] wr [5] = '{4'b1000, 4'b0100, 4'b0001, 4'b0010, 4'b0010};
   logic [1:0] el [5] = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd3};
   logic [1:0] er [5] = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd1};
   logic [2:0] es [5] = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd3};

   outer1bits_span #(.WIDTH(4), .FIFO_DEPTH(4)) dut (
      .clk_i        (clk),
      .srst_n_i     (srst_n),
      .data_val_i   (data_val),
      .data_left_i  (data_left),
      .data_right_i (data_right),
      .data_val_o   (val_o),
      .data_ready_i (data_ready),
      .left_idx_o   (left_idx),
      .right_idx_o  (right_idx),
      .span_o       (span),
      .zero_o       (zero),
      .fill_o       (fill),
      .err_o        (err),
      .ovf_o        (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      srst_n   = 1'b0;
      data_val = 1'b0;
      tick();
      tick();
      srst_n = 1'b1;
   endtask

   task automatic send(input logic [3:0] l, input logic [3:0] r);
      data_left  = l;
      data_right = r;
      data_val   = 1'b1;
      tick();
      data_val = 1'b0;
      tick();
   endtask

   task automatic expect_head(input string tag, input logic [1:0] l, input logic [1:0] r,
                              input logic [2:0] s, input logic z);
      check({tag, ".val"},  val_o,     1);
      check({tag, ".lidx"}, left_idx,  l);
      check({tag, ".ridx"}, right_idx, r);
      check({tag, ".span"}, span,      s);
      check({tag, ".zero"}, zero,      z);
   endtask

   initial begin
      do_reset();
      check("rst.val",  val_o, 0);
      check("rst.fill", fill,  0);
      check("rst.err",  err,   0);
      check("rst.ovf",  ovf,   0);
      check("rst.span", span,  0);
      check("rst.lidx", left_idx, 0);
      check("rst.zero", zero,  0);

      // 1: basic word, two-edge latency, popped by ready
      data_ready = 1'b1;
      data_left  = 4'b0100;
      data_right = 4'b0010;
      data_val   = 1'b1;
      tick();
      data_val = 1'b0;
      check("t1.lat1", val_o, 0);
      tick();
      expect_head("t1", 2'd2, 2'd1, 3'd2, 1'b0);
      check("t1.fill", fill, 1);
      tick();
      check("t1.popval",  val_o, 0);
      check("t1.popfill", fill,  0);

      // 2: zero word
      send(4'b0000, 4'b0000);
      expect_head("t2", 2'd0, 2'd0, 3'd0, 1'b1);
      tick();

      // 3: widest and narrowest spans
      send(4'b1000, 4'b0001);
      expect_head("t3a", 2'd3, 2'd0, 3'd4, 1'b0);
      tick();
      send(4'b0001, 4'b0001);
      expect_head("t3b", 2'd0, 2'd0, 3'd1, 1'b0);
      tick();
      check("t3.err", err, 0);
      check("t3.ovf", ovf, 0);

      // 4a: multi-hot mask is rejected, err is sticky, later good word still accepted
      data_ready = 1'b0;
      send(4'b0011, 4'b0001);
      check("t4a.err",  err,   1);
      check("t4a.val",  val_o, 0);
      check("t4a.fill", fill,  0);
      tick();
      tick();
      check("t4a.hold", err, 1);
      send(4'b0100, 4'b0100);
      expect_head("t4a.good", 2'd2, 2'd2, 3'd1, 1'b0);
      check("t4a.err2", err, 1);

      // 4b: left below right, err appears at the second edge
      do_reset();
      check("t4b.rsterr", err, 0);
      data_left  = 4'b0010;
      data_right = 4'b0100;
      data_val   = 1'b1;
      tick();
      data_val = 1'b0;
      check("t4b.early", err, 0);
      tick();
      check("t4b.err",  err,  1);
      check("t4b.fill", fill, 0);

      // 4c: exactly one mask zero
      do_reset();
      send(4'b0100, 4'b0000);
      check("t4c.err",  err,   1);
      check("t4c.val",  val_o, 0);

      // 5: overflow with ready low, then drain in order
      do_reset();
      data_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         data_left  = wl[i];
         data_right = wr[i];
         data_val   = 1'b1;
         tick();
      end
      data_val = 1'b0;
      check("t5.fill4", fill, 4);
      check("t5.noovf", ovf,  0);
      tick();
      check("t5.fill", fill, 4);
      check("t5.ovf",  ovf,  1);
      data_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         expect_head($sformatf("t5.w%0d", i), el[i], er[i], es[i], 1'b0);
         tick();
      end
      check("t5.emptyval",  val_o, 0);
      check("t5.emptyfill", fill,  0);
      check("t5.ovfhold",   ovf,   1);

      // 6: full FIFO with push and pop in one cycle
      do_reset();
      data_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         data_left  = wl[i];
         data_right = wr[i];
         data_val   = 1'b1;
         tick();
      end
      data_val   = 1'b0;
      check("t6.full", fill, 4);
      data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
      check("t6.fill", fill, 4);
      check("t6.ovf",  ovf,  0);
      data_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         expect_head($sformatf("t6.w%0d", i), el[i], er[i], es[i], 1'b0);
         tick();
      end
      check("t6.empty", val_o, 0);

      // 6b: reset with three buffered words, a set err and a word in flight
      data_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         data_left  = wl[i];
         data_right = wr[i];
         data_val   = 1'b1;
         tick();
      end
      data_val = 1'b0;
      tick();
      check("t6b.fill3", fill, 3);
      send(4'b0110, 4'b0010);
      check("t6b.err", err, 1);
      data_left  = 4'b1000;
      data_right = 4'b0001;
      data_val   = 1'b1;
      srst_n     = 1'b0;
      tick();
      check("t6b.fill", fill,  0);
      check("t6b.val",  val_o, 0);
      check("t6b.errc", err,   0);
      check("t6b.ovfc", ovf,   0);
      check("t6b.span", span,  0);
      srst_n   = 1'b1;
      data_val = 1'b0;
      tick();
      tick();
      check("t6b.noflight", fill, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
